// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: shared constants for the gate response checker.
//   - FSM state encodings (2-bit, legacy-compatible values)
//   - MISR feedback polynomial (x^16+x^12+x^5+1)
//   - 2-input truth-table constants; bit i = expected output for vector i
package gate_chk_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [15:0] MISR_POLY = 16'h1021;

  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_chk_misr.sv
// gate_chk_misr: 16-bit multiple-input signature register folding each
// checked (vector, dut output) sample into a running signature.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   i_clear    in   clear signature (run entry); has priority over i_en
//   i_en       in   fold the current sample into the signature
//   i_vec      in   [N_IN] gate input vector
//   i_dut_out  in   gate output for i_vec
//   o_sig      out  [16] current signature
// N_IN must be <= 15 so {vec, dut_out} fits in the 16-bit data word.
module gate_chk_misr
  import gate_chk_pkg::*;
#(
  parameter int unsigned N_IN = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clear,
  input  logic            i_en,
  input  logic [N_IN-1:0] i_vec,
  input  logic            i_dut_out,
  output logic [15:0]     o_sig
);

  logic [15:0] r_sig;
  logic [15:0] w_data;
  logic [15:0] w_shift;

  assign w_data  = 16'({i_vec, i_dut_out});
  assign w_shift = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? MISR_POLY : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (i_clear) begin
      r_sig <= '0;
    end else if (i_en) begin
      r_sig <= w_shift ^ w_data;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/gate_response_checker.sv
// gate_response_checker: samples (vector, gate output) pairs during a run,
// compares each output against TRUTH_TABLE, and accumulates a saturating
// mismatch count, input coverage and the first failing vector. pass is
// decided on the RUN->DONE edge.
// Optional feature macro GATE_CHK_MISR_EN: adds the 16-bit signature output
// driven by gate_chk_misr; without it the port and the MISR are absent.
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   synchronous active-low reset
//   start          in   begin a run (accepted in IDLE or DONE)
//   stop           in   end the run (accepted in RUN)
//   vec_valid      in   vec/dut_out valid this cycle
//   vec            in   [N_IN] gate input vector
//   dut_out        in   gate output for vec
//   busy           out  in RUN
//   done           out  in DONE
//   pass           out  no errors and full coverage (valid while done)
//   err_cnt        out  [ERR_W] saturating mismatch count
//   cov            out  [2**N_IN] vectors seen this run
//   first_err_vld  out  a mismatch was captured this run
//   first_err_vec  out  [N_IN] vector of first mismatch
//   signature      out  [16] MISR signature (GATE_CHK_MISR_EN only)
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned               N_IN        = 2,
  parameter logic [(1<<N_IN)-1:0]      TRUTH_TABLE = TT_NAND,
  parameter int unsigned               ERR_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 vec_valid,
  input  logic [N_IN-1:0]      vec,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [(1<<N_IN)-1:0] cov,
  output logic                 first_err_vld,
  output logic [N_IN-1:0]      first_err_vec
`ifdef GATE_CHK_MISR_EN
  ,
  output logic [15:0]          signature
`endif
);

  localparam int unsigned COV_W = 1 << N_IN;

  logic [1:0]       r_state;
  logic [ERR_W-1:0] r_err_cnt;
  logic [COV_W-1:0] r_cov;
  logic             r_first_vld;
  logic [N_IN-1:0]  r_first_vec;
  logic             r_pass;

  logic             w_check;
  logic             w_mismatch;
  logic             w_enter_run;
  logic [ERR_W-1:0] w_err_next;
  logic [COV_W-1:0] w_cov_next;

  assign w_check     = (r_state == ST_RUN) && vec_valid;
  assign w_mismatch  = w_check && (dut_out != TRUTH_TABLE[vec]);
  assign w_enter_run = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Next-cycle values are shared by the RUN update and the pass decision so
  // a sample taken together with stop is included in the verdict.
  assign w_err_next = (w_mismatch && !(&r_err_cnt)) ? r_err_cnt + ERR_W'(1) : r_err_cnt;
  assign w_cov_next = w_check ? (r_cov | (COV_W'(1) << vec)) : r_cov;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_err_cnt   <= '0;
      r_cov       <= '0;
      r_first_vld <= 1'b0;
      r_first_vec <= '0;
      r_pass      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state     <= ST_RUN;
            r_err_cnt   <= '0;
            r_cov       <= '0;
            r_first_vld <= 1'b0;
            r_first_vec <= '0;
            r_pass      <= 1'b0;
          end
        end
        ST_RUN: begin
          r_err_cnt <= w_err_next;
          r_cov     <= w_cov_next;
          if (w_mismatch && !r_first_vld) begin
            r_first_vld <= 1'b1;
            r_first_vec <= vec;
          end
          if (stop) begin
            r_state <= ST_DONE;
            r_pass  <= (w_err_next == '0) && (&w_cov_next);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy          = (r_state == ST_RUN);
  assign done          = (r_state == ST_DONE);
  assign pass          = r_pass;
  assign err_cnt       = r_err_cnt;
  assign cov           = r_cov;
  assign first_err_vld = r_first_vld;
  assign first_err_vec = r_first_vec;

`ifdef GATE_CHK_MISR_EN
  gate_chk_misr #(
    .N_IN(N_IN)
  ) u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_enter_run),
    .i_en      (w_check),
    .i_vec     (vec),
    .i_dut_out (dut_out),
    .o_sig     (signature)
  );
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: drives two checker instances (ERR_W=8 and ERR_W=2)
// from one stimulus stream and compares them to a run-log reference model.
module tb_gate_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, stop, vec_valid, dut_out;
  logic [1:0] vec;

  logic       busy0, done0, pass0, fvld0;
  logic [7:0] err0;
  logic [3:0] cov0;
  logic [1:0] fvec0;
  logic       busy1, done1, pass1, fvld1;
  logic [1:0] err1;
  logic [3:0] cov1;
  logic [1:0] fvec1;
`ifdef GATE_CHK_MISR_EN
  logic [15:0] sig0, sig1;
`endif

  gate_response_checker #(.N_IN(2), .TRUTH_TABLE(4'b0111), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .vec_valid(vec_valid),
    .vec(vec), .dut_out(dut_out), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .cov(cov0), .first_err_vld(fvld0), .first_err_vec(fvec0)
`ifdef GATE_CHK_MISR_EN
    , .signature(sig0)
`endif
  );

  gate_response_checker #(.N_IN(2), .TRUTH_TABLE(4'b0111), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .vec_valid(vec_valid),
    .vec(vec), .dut_out(dut_out), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .cov(cov1), .first_err_vld(fvld1), .first_err_vec(fvec1)
`ifdef GATE_CHK_MISR_EN
    , .signature(sig1)
`endif
  );

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  // Reference model: phase of the run plus the log of samples checked in it.
  typedef enum int {M_IDLE, M_RUN, M_DONE} mphase_t;
  mphase_t  m_phase = M_IDLE;
  bit [1:0] q_vec[$];
  bit       q_out[$];
  bit       m_pass = 1'b0;
  bit [3:0] tt = 4'b0111;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_errs();
    int e = 0;
    foreach (q_vec[i]) if (q_out[i] != tt[q_vec[i]]) e++;
    return e;
  endfunction

  function automatic bit [3:0] m_cov();
    bit [3:0] c = '0;
    foreach (q_vec[i]) c[q_vec[i]] = 1'b1;
    return c;
  endfunction

  function automatic bit [2:0] m_first();  // {vld, vec}
    foreach (q_vec[i]) if (q_out[i] != tt[q_vec[i]]) return {1'b1, q_vec[i]};
    return 3'b000;
  endfunction

  function automatic bit [15:0] m_sig();
    bit [15:0] s = '0;
    foreach (q_vec[i]) s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {13'b0, q_vec[i], q_out[i]};
    return s;
  endfunction

  task automatic check_all(input string tag);
    int e = m_errs();
    bit [2:0] f = m_first();
    chk({tag, ".busy"}, busy0, m_phase == M_RUN);
    chk({tag, ".done"}, done0, m_phase == M_DONE);
    chk({tag, ".pass"}, pass0, m_pass);
    chk({tag, ".err"},  err0, (e > 255) ? 255 : e);
    chk({tag, ".err_sat"}, err1, (e > 3) ? 3 : e);
    chk({tag, ".cov"},  cov0, m_cov());
    chk({tag, ".fvld"}, fvld0, f[2]);
    chk({tag, ".fvec"}, fvec0, f[1:0]);
    chk({tag, ".fvec_sat"}, fvec1, f[1:0]);
    chk({tag, ".pass_sat"}, pass1, m_pass);
`ifdef GATE_CHK_MISR_EN
    chk({tag, ".sig"}, sig0, m_sig());
`endif
  endtask

  // One clock with the given inputs; model follows the state rules, then check.
  task automatic cyc(input string tag, input bit s, input bit p, input bit v,
                     input bit [1:0] x, input bit o);
    start = s; stop = p; vec_valid = v; vec = x; dut_out = o;
    @(posedge clk); #1;
    if (!rst_n) begin
      m_phase = M_IDLE; q_vec.delete(); q_out.delete(); m_pass = 1'b0;
    end else if (m_phase == M_RUN) begin
      if (v) begin q_vec.push_back(x); q_out.push_back(o); end
      if (p) begin
        m_phase = M_DONE;
        m_pass  = (m_errs() == 0) && (m_cov() == 4'hF);
      end
    end else if (s) begin
      m_phase = M_RUN; q_vec.delete(); q_out.delete(); m_pass = 1'b0;
    end
    start = 0; stop = 0; vec_valid = 0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    cyc(tag, 0, 0, 0, 2'd0, 0);
    rst_n = 1'b1;
  endtask

  // Full 4-vector stream; bad11 flips the output for vector 11.
  task automatic stream4(input string tag, input bit bad11);
    cyc(tag, 1, 0, 0, 2'd0, 0);
    for (int unsigned i = 0; i < 4; i++) cyc(tag, 0, 0, 1, 2'(i), tt[i] ^ (bad11 && i == 3));
    cyc(tag, 0, 1, 0, 2'd0, 0);
  endtask

  bit [15:0] sig_t1, sig_t2;

  initial begin
    rst_n = 1'b1; start = 0; stop = 0; vec_valid = 0; vec = '0; dut_out = 0;
    do_reset("reset");

    stream4("t1_nand", 1'b0);
    chk("t1_pass", pass0, 1'b1);
    chk("t1_cov", cov0, 4'b1111);
`ifdef GATE_CHK_MISR_EN
    sig_t1 = sig0;
`endif

    stream4("t2_bad", 1'b1);
    chk("t2_fvec", fvec0, 2'b11);
    chk("t2_err", err0, 8'd1);
`ifdef GATE_CHK_MISR_EN
    sig_t2 = sig0;
    chk("t6_sig_differs", sig_t1 != sig_t2, 1'b1);
`endif

    cyc("t3_part", 1, 0, 0, 2'd0, 0);
    for (int unsigned i = 0; i < 3; i++) cyc("t3_part", 0, 0, 1, 2'(i), tt[i]);
    cyc("t3_part", 0, 1, 0, 2'd0, 0);
    chk("t3_cov", cov0, 4'b0111);

    // Five mismatches, first on vector 10; narrow instance saturates at 3.
    cyc("t4_sat", 1, 0, 0, 2'd0, 0);
    cyc("t4_sat", 0, 0, 1, 2'd1, 1);
    for (int unsigned i = 0; i < 5; i++) cyc("t4_sat", 0, 0, 1, 2'(2 + (i % 2)), ~tt[2 + (i % 2)]);
    cyc("t4_sat", 0, 1, 0, 2'd0, 0);
    chk("t4_err_sat", err1, 2'b11);
    chk("t4_fvec", fvec1, 2'b10);

    // stop together with the last valid sample still counts it.
    cyc("t5_stopv", 1, 0, 0, 2'd0, 0);
    for (int unsigned i = 0; i < 3; i++) cyc("t5_stopv", 0, 0, 1, 2'(i), tt[i]);
    cyc("t5_stopv", 0, 1, 1, 2'd3, tt[3]);
    chk("t5_pass", pass0, 1'b1);

    // start in RUN must not clear accumulated state.
    cyc("t5_startrun", 1, 0, 0, 2'd0, 0);
    cyc("t5_startrun", 0, 0, 1, 2'd0, 0);
    cyc("t5_startrun", 1, 0, 1, 2'd1, 1);
    chk("t5_noclear", err0, 8'd1);

    // reset mid-run discards everything.
    rst_n = 1'b0;
    cyc("t5_rst", 0, 0, 1, 2'd3, 1);
    rst_n = 1'b1;
    chk("t5_rst_busy", busy0, 1'b0);
    cyc("t5_idle_stop", 0, 1, 1, 2'd3, 1);

    for (int unsigned r = 0; r < 30; r++) begin
      int unsigned n = $urandom_range(0, 10);
      cyc("rnd_start", 1, 0, $urandom_range(0, 1), 2'($urandom), 1'($urandom));
      for (int unsigned k = 0; k < n; k++) begin
        bit [1:0] x = 2'($urandom);
        cyc("rnd_run", ($urandom_range(0, 7) == 0), 0, ($urandom_range(0, 3) != 0),
            x, tt[x] ^ ($urandom_range(0, 5) == 0));
      end
      if (r % 9 == 4) begin
        do_reset("rnd_rst");
      end else begin
        bit [1:0] x = 2'($urandom);
        cyc("rnd_stop", 0, 1, $urandom_range(0, 1), x, tt[x] ^ ($urandom_range(0, 5) == 0));
        cyc("rnd_done", 0, $urandom_range(0, 1), 1, 2'($urandom), 1'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
